tl_peri_mem_slave: RTL and testbench

//  TileLink-UL memory slave in the 24 MHz peripheral domain, directly downstream of the

---
 rtl/tl_peri_pkg.sv | 6 +
 rtl/tl_peri_sram.sv | 21 ++
 rtl/tl_peri_mem_slave.sv | 119 +++++++++++
 tb/tb_tl_peri_mem_slave.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/tl_peri_pkg.sv
// tl_peri_pkg: TileLink-UL opcodes and slave FSM states shared by the peripheral memory slave
package tl_peri_pkg;
  typedef enum logic [2:0] {PUT_FULL = 3'd0, PUT_PARTIAL = 3'd1, GET = 3'd4} tl_a_opcode_e;
  typedef enum logic [2:0] {ACCESS_ACK = 3'd0, ACCESS_ACK_DATA = 3'd1} tl_d_opcode_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} slave_state_e;
endpackage

// File: rtl/tl_peri_sram.sv
// tl_peri_sram: word array with byte write enables, synchronous write, combinational read, contents never reset
module tl_peri_sram #(
  parameter int DEPTH_WORDS = 256,
  parameter int DATA_WIDTH  = 32,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [AW-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  // write only the enabled byte lanes of the addressed word
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < DATA_WIDTH/8; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/tl_peri_mem_slave.sv
// tl_peri_mem_slave: TileLink-UL memory slave, one outstanding request, programmable latency; TL_PERI_ERR_CNT_EN adds err_count
module tl_peri_mem_slave #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MASK_WIDTH   = DATA_WIDTH/8,
  parameter int SIZE_WIDTH   = 3,
  parameter int SRC_WIDTH    = 2,
  parameter int SINK_WIDTH   = 1,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h1000_0000,
  parameter int DEPTH_WORDS  = 256,
  parameter int RESP_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [OPCODE_WIDTH-1:0] a_opcode,
  input  logic [PARAM_WIDTH-1:0]  a_param,
  input  logic [SIZE_WIDTH-1:0]   a_size,
  input  logic [SRC_WIDTH-1:0]    a_source,
  input  logic [ADDR_WIDTH-1:0]   a_address,
  input  logic [MASK_WIDTH-1:0]   a_mask,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    d_valid,
  input  logic                    d_ready,
  output logic [OPCODE_WIDTH-1:0] d_opcode,
  output logic [PARAM_WIDTH-1:0]  d_param,
  output logic [SIZE_WIDTH-1:0]   d_size,
  output logic [SRC_WIDTH-1:0]    d_source,
  output logic [SINK_WIDTH-1:0]   d_sink,
  output logic [DATA_WIDTH-1:0]   d_data,
  output logic                    d_error
`ifdef TL_PERI_ERR_CNT_EN
  ,output logic [15:0]            err_count
`endif
);
  import tl_peri_pkg::*;
  localparam int LANE_BITS = $clog2(MASK_WIDTH);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] WINDOW = ADDR_WIDTH'(DEPTH_WORDS * MASK_WIDTH);
  slave_state_e state;
  logic [2:0] cnt;
  logic a_fire, legal, is_get, op_ok, size_ok, align_ok, win_ok, full_ok;
  logic [ADDR_WIDTH-1:0] offset;
  logic [LANE_BITS-1:0] lane_off;
  logic [MASK_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] rdata;
  assign a_fire   = a_valid && a_ready;
  assign offset   = a_address - BASE_ADDR;
  assign lane_off = a_address[LANE_BITS-1:0];
  assign is_get   = a_opcode == GET;
  assign op_ok    = a_opcode inside {PUT_FULL, PUT_PARTIAL, GET};
  assign size_ok  = int'(a_size) <= LANE_BITS;
  assign align_ok = ((int'(lane_off) >> a_size) << a_size) == int'(lane_off);
  assign win_ok   = offset < WINDOW;
  assign full_ok  = (a_opcode != PUT_FULL) || ((a_mask & lane_mask) == lane_mask);
  assign legal    = op_ok && a_param == '0 && size_ok && align_ok && win_ok && full_ok;
  assign d_param  = '0;
  assign d_sink   = '0;
  // lanes covered by the naturally aligned 2^a_size block that holds the address
  always_comb
    for (int i = 0; i < MASK_WIDTH; i++)
      lane_mask[i] = (i >> a_size) == (int'(lane_off) >> a_size);
  tl_peri_sram #(.DEPTH_WORDS(DEPTH_WORDS), .DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_sram (
    .clk  (clk),
    .we   (a_fire && legal && !is_get),
    .be   (a_mask),
    .addr (offset[LANE_BITS +: AW]),
    .wdata(a_data),
    .rdata(rdata)
  );
  // request/response FSM; the whole D payload is captured at A fire and held until D fire
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_ready  <= 1'b1;
      d_valid  <= 1'b0;
      d_opcode <= '0;
      d_size   <= '0;
      d_source <= '0;
      d_data   <= '0;
      d_error  <= 1'b0;
    end else
      case (state)
        IDLE:
          if (a_fire) begin
            a_ready  <= 1'b0;
            d_opcode <= OPCODE_WIDTH'(is_get ? ACCESS_ACK_DATA : ACCESS_ACK);
            d_size   <= a_size;
            d_source <= a_source;
            d_data   <= legal && is_get ? rdata : '0;
            d_error  <= !legal;
            cnt      <= 3'(RESP_LATENCY - 2);
            state    <= RESP_LATENCY > 1 ? WAIT : RESP;
            d_valid  <= RESP_LATENCY == 1;
          end
        WAIT:
          if (cnt == '0) begin
            state   <= RESP;
            d_valid <= 1'b1;
          end else cnt <= cnt - 3'd1;
        RESP:
          if (d_ready) begin
            state   <= IDLE;
            d_valid <= 1'b0;
            a_ready <= 1'b1;
          end
        default: state <= IDLE;
      endcase
`ifdef TL_PERI_ERR_CNT_EN
  // count error responses as they are accepted, sticking at all-ones
  always_ff @(posedge clk or posedge reset)
    if (reset) err_count <= '0;
    else if (d_valid && d_ready && d_error && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`endif
endmodule

// File: tb/tb_tl_peri_mem_slave.sv
// tb_tl_peri_mem_slave: randomized scoreboard bench for tl_peri_mem_slave (RESP_LATENCY=4)
module tb_tl_peri_mem_slave;
  localparam int LAT = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int WIN = 1024;
  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [1:0]  src;
    logic        err;
    logic [31:0] data;
  } resp_t;
  logic clk = 0, reset = 1;
  logic a_valid = 0, a_ready, d_valid, d_ready = 0, d_error;
  logic [2:0] a_opcode = 0, a_param = 0, a_size = 0, d_opcode, d_param, d_size;
  logic [1:0] a_source = 0, d_source;
  logic [31:0] a_address = 0, a_data = 0, d_data;
  logic [3:0] a_mask = 0;
  logic [0:0] d_sink;
`ifdef TL_PERI_ERR_CNT_EN
  logic [15:0] err_count;
  int mdl_err = 0;
`endif
  resp_t exp_q[$];
  logic [7:0] mdl [WIN];
  int checks = 0, failures = 0, cyc = 0, fire_cyc = 0, dr_mode = 0;
  bit busy = 0, stalled = 0, prev_dv = 0;
  logic [63:0] held;

  tl_peri_mem_slave #(.RESP_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data), .d_error(d_error)
`ifdef TL_PERI_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  always #20 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] pk(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                                     input logic [1:0] src, input logic snk, input logic err, input logic [31:0] dat);
    return {19'd0, op, prm, sz, src, snk, err, dat};
  endfunction

  function automatic logic [63:0] d_pk();
    return pk(d_opcode, d_param, d_size, d_source, d_sink[0], d_error, d_data);
  endfunction

  // reference: legality from the rules, byte-array memory, response built from the request
  function automatic resp_t model(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                                  input logic [1:0] src, input logic [31:0] addr, input logic [3:0] mask,
                                  input logic [31:0] data);
    resp_t r;
    bit ok;
    int bytes, off, wb;
    ok = (op == 0 || op == 1 || op == 4) && prm == 0 && sz <= 2 && addr >= BASE && addr < BASE + WIN;
    bytes = sz <= 2 ? (1 << sz) : 1;
    off = int'(addr - BASE);
    if (ok && (off % bytes) != 0) ok = 0;
    if (ok && op == 0)
      for (int k = 0; k < bytes; k++) if (!mask[(off % 4) + k]) ok = 0;
    r.op = op == 4 ? 3'd1 : 3'd0;
    r.size = sz;
    r.src = src;
    r.err = !ok;
    r.data = 0;
    wb = off - (off % 4);
    if (ok && op == 4) r.data = {mdl[wb+3], mdl[wb+2], mdl[wb+1], mdl[wb]};
    if (ok && op != 4)
      for (int l = 0; l < 4; l++) if (mask[l]) mdl[wb+l] = data[8*l +: 8];
    return r;
  endfunction

  // issue one A request; while a_ready is low drive a legal-looking junk Put that must be ignored
  task automatic send(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz, input logic [1:0] src,
                      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    int n = 0;
    @(posedge clk); #2;
    while (!a_ready) begin
      a_valid = 1; a_opcode = 0; a_param = 0; a_size = 2; a_source = 2'($urandom);
      a_address = BASE + 32'($urandom_range(0, 7) * 4); a_mask = 4'hF; a_data = $urandom;
      n++;
      if (n > 200) begin
        chk("a_ready_timeout", 64'(a_ready), 64'd1);
        a_valid = 0;
        return;
      end
      @(posedge clk); #2;
    end
    a_valid = 1; a_opcode = op; a_param = prm; a_size = sz; a_source = src;
    a_address = addr; a_mask = mask; a_data = data;
    exp_q.push_back(model(op, prm, sz, src, addr, mask, data));
    @(posedge clk); #2;
    a_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // d_ready: random, forced low, or forced high
  initial forever begin
    @(posedge clk); #2;
    d_ready = dr_mode == 1 ? 1'b0 : dr_mode == 2 ? 1'b1 : ($urandom_range(0, 3) != 0);
  end

  // monitor: protocol checks every cycle, scoreboard compare on each D fire
  always @(negedge clk) begin
    resp_t e;
    cyc++;
    if (reset) begin
      chk("reset_handshake", {62'd0, a_ready, d_valid}, 64'b10);
      exp_q.delete();
      busy = 0;
      stalled = 0;
`ifdef TL_PERI_ERR_CNT_EN
      mdl_err = 0;
`endif
    end else begin
      chk("a_ready_busy", 64'(a_ready), 64'(!busy));
      if (stalled) chk("stall_hold", {d_valid, d_pk()}, {1'b1, held});
      if (d_valid && !prev_dv) chk("latency", 64'(cyc - fire_cyc), 64'(LAT));
      if (a_valid && a_ready) begin busy = 1; fire_cyc = cyc; end
      if (d_valid && d_ready) begin
        if (exp_q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("resp", d_pk(), pk(e.op, 3'd0, e.size, e.src, 1'b0, e.err, e.data));
`ifdef TL_PERI_ERR_CNT_EN
          chk("err_count_run", 64'(err_count), 64'(mdl_err));
          if (e.err && mdl_err < 65535) mdl_err++;
`endif
        end
        busy = 0;
      end
      stalled = d_valid && !d_ready;
      held = d_pk();
    end
    prev_dv = d_valid;
  end

  initial begin
    logic [2:0] op, sz, prm;
    logic [31:0] addr;
    logic [3:0] mask;
    int r;
    repeat (2) @(negedge clk);
    chk("reset_payload", d_pk(), 64'd0);
    @(posedge clk); #2 reset = 0;
    dr_mode = 2;
    send(0, 0, 2, 1, BASE + 4, 4'hF, 32'hDEADBEEF);
    send(4, 0, 2, 1, BASE + 4, 4'hF, 32'h0);
    send(1, 0, 2, 0, BASE + 4, 4'h2, 32'h0000_5500);
    send(4, 0, 2, 0, BASE + 4, 4'hF, 32'h0);
    send(4, 0, 2, 2, 32'h2000_0000, 4'hF, 32'h0);
    send(4, 0, 2, 0, BASE + 2, 4'hF, 32'h0);
    send(6, 0, 2, 3, BASE + 4, 4'hF, 32'h1111_1111);
    send(0, 0, 2, 0, BASE + 4, 4'h7, 32'h2222_2222);
    send(0, 1, 2, 0, BASE + 4, 4'hF, 32'h3333_3333);
    send(0, 0, 3, 0, BASE + 8, 4'hF, 32'h4444_4444);
    send(0, 0, 2, 0, BASE + 1024, 4'hF, 32'h5555_5555);
    send(4, 0, 2, 0, BASE - 4, 4'hF, 32'h0);
    send(4, 0, 2, 0, BASE + 4, 4'hF, 32'h0);
    send(0, 0, 2, 2, BASE + 1020, 4'hF, 32'hCAFE_F00D);
    send(4, 0, 2, 2, BASE + 1020, 4'hF, 32'h0);
    send(0, 0, 1, 1, BASE + 1022, 4'hC, 32'hABCD_0000);
    send(4, 0, 0, 3, BASE + 1023, 4'h8, 32'h0);
    for (int i = 0; i < 8; i++) send(0, 0, 2, 2'(i), BASE + 32'(4 * i), 4'hF, $urandom);
    wait_idle();
    dr_mode = 0;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      op = r < 4 || r == 9 ? 3'd4 : r < 6 ? 3'd0 : r < 8 ? 3'd1 : 3'({$urandom_range(1, 3), 1'b1});
      sz = $urandom_range(0, 9) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      prm = $urandom_range(0, 14) == 0 ? 3'($urandom_range(1, 7)) : 3'd0;
      r = $urandom_range(0, 9);
      addr = r == 0 ? BASE - 4 : r == 1 ? BASE + WIN : BASE + 32'($urandom_range(0, 31));
      mask = op == 0 && $urandom_range(0, 3) != 0 ? 4'hF : 4'($urandom);
      send(op, prm, sz, 2'($urandom), addr, mask, $urandom);
    end
    wait_idle();
    dr_mode = 1;
    send(4, 0, 2, 1, BASE + 1020, 4'hF, 32'h0);
    repeat (10) @(posedge clk);
    dr_mode = 2;
    wait_idle();
    send(4, 0, 2, 0, BASE + 4, 4'hF, 32'h0);
    @(posedge clk); #2 reset = 1;
    @(posedge clk); #2 reset = 0;
    send(4, 0, 2, 3, BASE + 4, 4'hF, 32'h0);
    send(4, 0, 2, 3, BASE + 1020, 4'hF, 32'h0);
    wait_idle();
`ifdef TL_PERI_ERR_CNT_EN
    @(posedge clk); #2 reset = 1;
    @(posedge clk); #2 reset = 0;
    send(6, 0, 2, 0, BASE, 4'hF, 32'h0);
    send(4, 0, 2, 0, 32'h2000_0000, 4'hF, 32'h0);
    send(4, 0, 2, 0, BASE + 2, 4'hF, 32'h0);
    wait_idle();
    chk("err_count_3", 64'(err_count), 64'd3);
    send(0, 0, 2, 0, BASE + 12, 4'hF, 32'h7777_7777);
    send(4, 0, 2, 0, BASE + 12, 4'hF, 32'h0);
    wait_idle();
    chk("err_count_hold", 64'(err_count), 64'd3);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
